// File: rtl/pipe_pkg.sv
// Shared types for the MEM/WB end of the 16-bit pipeline: FSM states, the
// EX->MEM instruction record and the write-enable rule for write-back.
package pipe_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int REG_AW_DEF = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      WB   = 2'd3
   } mem_wb_state_t;

   // Field widths follow the package defaults; the stage is built at those widths.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] res_ula;
      logic [DATA_W_DEF-1:0] store_data;
      logic [REG_AW_DEF-1:0] dest;
      logic                  wr_en;
      logic                  mem_rd;
      logic                  mem_wr;
   } ex_mem_t;

   // A pure store never writes the register file; load+store counts as a load.
   function automatic logic wb_write_en(input ex_mem_t x);
      return x.wr_en & ~(x.mem_wr & ~x.mem_rd);
   endfunction

endpackage

// File: rtl/mem_wb_stage_mem_if_ctrl.sv
// Data-memory handshake for mem_wb_stage: request/grant decode, the
// WAIT-state response check and capture of load data.
module mem_if_ctrl
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              in_req_i,
   input  logic              in_wait_i,
   input  logic              is_load_i,
   input  logic              is_store_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              gnt_i,
   input  logic              rvalid_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              done_o,
   output logic              wait_o,
   output logic [DATA_W-1:0] rdata_o
);

   logic              wr;
   logic              cap;
   logic [DATA_W-1:0] md_q;
   logic [DATA_W-1:0] md_d;

   assign wr          = is_store_i & ~is_load_i;
   assign mem_req_o   = in_req_i;
   assign mem_we_o    = in_req_i & wr;
   assign mem_addr_o  = in_req_i ? addr_i : '0;
   assign mem_wdata_o = (in_req_i && wr) ? wdata_i : '0;

   // A response can land in the grant cycle itself, letting a load skip WAIT.
   assign cap    = (in_req_i & gnt_i & is_load_i & rvalid_i) | (in_wait_i & rvalid_i);
   assign done_o = (in_req_i & gnt_i & (~is_load_i | rvalid_i)) | (in_wait_i & rvalid_i);
   assign wait_o = in_req_i & gnt_i & is_load_i & ~rvalid_i;

   assign md_d    = cap ? rdata_i : md_q;
   assign rdata_o = md_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) md_q <= '0;
      else          md_q <= md_d;
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: accepts one EX instruction, runs the optional memory access
// and pulses the register-file write port. Define MEM_WB_FWD_EN for the
// same-cycle forwarding outputs toward ID.
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_res_ula,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [REG_AW-1:0] in_dest,
   input  logic              in_wr_en,
   input  logic              in_mem_rd,
   input  logic              in_mem_wr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] saida_ULA,
   output logic [DATA_W-1:0] saida_MD,
   output logic              controle_wb,
   output logic              BR_Hab_Escrita,
   output logic [REG_AW-1:0] BR_Sel_E,
   output logic              stall
`ifdef MEM_WB_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_dest,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   mem_wb_state_t     state_q;
   ex_mem_t           lat_q;
   ex_mem_t           in_f;
   logic [DATA_W-1:0] ula_q;
   logic [REG_AW-1:0] sel_q;
   logic              ctl_q;
   logic              we_q;
   logic              mem_done;
   logic              mem_wait;
   logic [DATA_W-1:0] md;

   assign in_f     = {in_res_ula, in_store_data, in_dest, in_wr_en, in_mem_rd, in_mem_wr};
   assign in_ready = (state_q == IDLE) || (state_q == WB);
   assign stall    = ~in_ready;

   mem_if_ctrl #(.DATA_W(DATA_W)) u_mem (
      .clk_i       (clock),
      .rst_n_i     (reset_n),
      .in_req_i    (state_q == REQ),
      .in_wait_i   (state_q == WAIT),
      .is_load_i   (lat_q.mem_rd),
      .is_store_i  (lat_q.mem_wr),
      .addr_i      (lat_q.res_ula),
      .wdata_i     (lat_q.store_data),
      .gnt_i       (mem_gnt),
      .rvalid_i    (mem_rvalid),
      .rdata_i     (mem_rdata),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .done_o      (mem_done),
      .wait_o      (mem_wait),
      .rdata_o     (md)
   );

   // Write-back outputs load only on entry to WB and otherwise hold;
   // the write enable alone is a single-cycle pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         lat_q   <= '0;
         ula_q   <= '0;
         sel_q   <= '0;
         ctl_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            IDLE, WB: begin
               if (in_valid) begin
                  lat_q <= in_f;
                  if (in_mem_rd || in_mem_wr) begin
                     state_q <= REQ;
                  end else begin
                     state_q <= WB;
                     ula_q   <= in_f.res_ula;
                     sel_q   <= in_f.dest;
                     ctl_q   <= in_f.mem_rd;
                     we_q    <= wb_write_en(in_f);
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            REQ, WAIT: begin
               if (mem_done) begin
                  state_q <= WB;
                  ula_q   <= lat_q.res_ula;
                  sel_q   <= lat_q.dest;
                  ctl_q   <= lat_q.mem_rd;
                  we_q    <= wb_write_en(lat_q);
               end else if (mem_wait) begin
                  state_q <= WAIT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign saida_ULA      = ula_q;
   assign saida_MD       = md;
   assign controle_wb    = ctl_q;
   assign BR_Hab_Escrita = we_q;
   assign BR_Sel_E       = sel_q;

`ifdef MEM_WB_FWD_EN
   assign fwd_valid = we_q;
   assign fwd_dest  = sel_q;
   assign fwd_data  = ctl_q ? md : ula_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed instructions, a cycle-indexed table of
// expected bus/write-back activity, and a per-cycle compare against it.
module tb_mem_wb_stage;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_res_ula, in_store_data;
   logic [2:0]  in_dest;
   logic        in_wr_en, in_mem_rd, in_mem_wr;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [15:0] mem_rdata;
   logic [15:0] saida_ULA, saida_MD;
   logic        controle_wb, BR_Hab_Escrita;
   logic [2:0]  BR_Sel_E;
   logic        stall;
`ifdef MEM_WB_FWD_EN
   logic        fwd_valid;
   logic [2:0]  fwd_dest;
   logic [15:0] fwd_data;
`endif

   mem_wb_stage dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_res_ula(in_res_ula), .in_store_data(in_store_data), .in_dest(in_dest),
      .in_wr_en(in_wr_en), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .saida_ULA(saida_ULA), .saida_MD(saida_MD), .controle_wb(controle_wb),
      .BR_Hab_Escrita(BR_Hab_Escrita), .BR_Sel_E(BR_Sel_E), .stall(stall)
`ifdef MEM_WB_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
`endif
   );

   always #5 clock = ~clock;

   // cyc = number of rising edges so far; "cycle k" is the interval after edge k.
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   typedef struct { logic en; logic [2:0] dest; logic [15:0] ula; logic ctl; } wb_e;
   typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } req_e;

   wb_e         exp_wb[int];
   req_e        exp_req[int];
   bit          exp_busy[int];
   logic [15:0] exp_md[int];

   task automatic idle_inputs();
      in_valid = 0; in_res_ula = 16'hFFFF; in_store_data = 16'hFFFF;
      in_dest = 3'd0; in_wr_en = 0; in_mem_rd = 0; in_mem_wr = 0;
   endtask

   task automatic drive(input logic [15:0] res, sd, input logic [2:0] dst,
                        input logic we_, rd, wr);
      in_valid = 1; in_res_ula = res; in_store_data = sd; in_dest = dst;
      in_wr_en = we_; in_mem_rd = rd; in_mem_wr = wr;
   endtask

   // Accepted at edge A; grant seen at edge G = A+1+g; load data at edge G+r.
   // Returns at the negedge of the write-back cycle.
   task automatic issue(input logic [15:0] res, sd, input logic [2:0] dst,
                        input logic we_, rd, wr, input int g, r,
                        input logic [15:0] rdat);
      int A, G, D;
      bit mem;
      wb_e w;
      req_e q;
      @(negedge clock);
      A   = cyc + 1;
      mem = rd || wr;
      G   = A + 1 + g;
      D   = !mem ? A : (rd ? G + r : G);
      drive(res, sd, dst, we_, rd, wr);
      if (mem) begin
         q.we = wr && !rd; q.addr = res; q.wdata = sd;
         for (int k = A; k < G; k++) exp_req[k] = q;
         for (int k = A; k < D; k++) exp_busy[k] = 1;
      end
      if (rd) exp_md[D] = rdat;
      w.en = (wr && !rd) ? 1'b0 : we_;
      w.dest = dst; w.ula = res; w.ctl = rd;
      exp_wb[D] = w;
      @(negedge clock);
      idle_inputs();
      if (mem) begin
         while (cyc < G - 1) @(negedge clock);
         mem_gnt = 1;
         if (rd && r == 0) begin mem_rvalid = 1; mem_rdata = rdat; end
         @(negedge clock);
         mem_gnt = 0; mem_rvalid = 0; mem_rdata = 16'hDEAD;
         if (rd && r > 0) begin
            while (cyc < D - 1) @(negedge clock);
            mem_rvalid = 1; mem_rdata = rdat;
            @(negedge clock);
            mem_rvalid = 0; mem_rdata = 16'hDEAD;
         end
      end
   endtask

   // Per-cycle compare against the expectation tables.
   logic [2:0]  h_dest = '0;
   logic [15:0] h_ula = '0, h_md = '0;
   logic        h_ctl = 1'b0;
   always @(posedge clock) begin
      bit pulse, busy, rq;
      #1;
      pulse = 0; busy = 0; rq = 0;
      if (!reset_n) begin
         h_dest = '0; h_ula = '0; h_ctl = 1'b0; h_md = '0;
      end else begin
         if (exp_wb.exists(cyc)) begin
            h_dest = exp_wb[cyc].dest; h_ula = exp_wb[cyc].ula;
            h_ctl = exp_wb[cyc].ctl;   pulse = exp_wb[cyc].en;
         end
         if (exp_md.exists(cyc)) h_md = exp_md[cyc];
         busy = exp_busy.exists(cyc);
         rq   = exp_req.exists(cyc);
      end
      chk("stall", stall, busy);
      chk("in_ready", in_ready, !busy);
      chk("mem_req", mem_req, rq);
      if (rq) begin
         chk("mem_addr", mem_addr, exp_req[cyc].addr);
         chk("mem_we", mem_we, exp_req[cyc].we);
         if (exp_req[cyc].we) chk("mem_wdata", mem_wdata, exp_req[cyc].wdata);
      end
      chk("BR_Hab_Escrita", BR_Hab_Escrita, pulse);
      chk("BR_Sel_E", BR_Sel_E, h_dest);
      chk("saida_ULA", saida_ULA, h_ula);
      chk("controle_wb", controle_wb, h_ctl);
      chk("saida_MD", saida_MD, h_md);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int A;
      reset_n = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 16'hDEAD;
      idle_inputs();
      repeat (3) @(negedge clock);
      reset_n = 1;
      chk("rst in_ready", in_ready, 1);
      chk("rst stall", stall, 0);
      chk("rst BR_Hab_Escrita", BR_Hab_Escrita, 0);
      chk("rst mem_req", mem_req, 0);

      // ALU op
      issue(16'h1234, 16'h0, 3'd5, 1, 0, 0, 0, 0, 16'h0);
      chk("alu pulse", BR_Hab_Escrita, 1);
      chk("alu sel", BR_Sel_E, 5);
      chk("alu ula", saida_ULA, 16'h1234);
      chk("alu ctl", controle_wb, 0);
      @(negedge clock);
      chk("alu pulse ends", BR_Hab_Escrita, 0);
      chk("alu ula holds", saida_ULA, 16'h1234);

      // Load: grant after 2 waiting cycles, data 3 cycles later
      issue(16'h0040, 16'h0, 3'd2, 1, 1, 0, 2, 3, 16'hBEEF);
      chk("ld md", saida_MD, 16'hBEEF);
      chk("ld ctl", controle_wb, 1);
      chk("ld pulse", BR_Hab_Escrita, 1);
      chk("ld sel", BR_Sel_E, 2);

      // Store with immediate grant
      issue(16'h0010, 16'h00AA, 3'd7, 1, 0, 1, 0, 0, 16'h0);
      chk("st no pulse", BR_Hab_Escrita, 0);

      // Back-to-back ALU ops, accepted from WB
      @(negedge clock);
      A = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         wb_e w;
         drive(16'h0101 * (i + 1), 16'h0, 3'(i + 1), 1, 0, 0);
         w.en = 1; w.dest = 3'(i + 1); w.ula = 16'h0101 * (i + 1); w.ctl = 0;
         exp_wb[A + i] = w;
         @(negedge clock);
      end
      idle_inputs();
      chk("b2b last sel", BR_Sel_E, 3);
      chk("b2b last ula", saida_ULA, 16'h0303);

      // Load with grant and data together
      issue(16'h0080, 16'h0, 3'd4, 1, 1, 0, 1, 0, 16'hCAFE);
      chk("ld0 md", saida_MD, 16'hCAFE);
      chk("ld0 pulse", BR_Hab_Escrita, 1);

      // Load and store both set: behaves as a load
      issue(16'h0022, 16'h9999, 3'd6, 1, 1, 1, 0, 1, 16'h7777);
      chk("ldst md", saida_MD, 16'h7777);
      chk("ldst pulse", BR_Hab_Escrita, 1);

      // ALU op without register write
      issue(16'h4242, 16'h0, 3'd3, 0, 0, 0, 0, 0, 16'h0);
      chk("nowr pulse", BR_Hab_Escrita, 0);
      chk("nowr ula", saida_ULA, 16'h4242);

      // Stray response while idle must be ignored
      @(negedge clock);
      mem_rvalid = 1; mem_rdata = 16'h1111;
      @(negedge clock);
      mem_rvalid = 0; mem_rdata = 16'hDEAD;
      chk("stray md", saida_MD, 16'h7777);

      // Reset while waiting for load data, then a late response
      @(negedge clock);
      A = cyc + 1;
      drive(16'h0300, 16'h0, 3'd5, 1, 1, 0);
      exp_req[A] = '{we: 1'b0, addr: 16'h0300, wdata: 16'h0};
      exp_busy[A] = 1; exp_busy[A + 1] = 1; exp_busy[A + 2] = 1;
      @(negedge clock);
      idle_inputs();
      mem_gnt = 1;
      @(negedge clock);
      mem_gnt = 0;
      chk("wait stall", stall, 1);
      @(negedge clock);
      reset_n = 0;
      #1;
      chk("rst2 in_ready", in_ready, 1);
      chk("rst2 md", saida_MD, 0);
      chk("rst2 ula", saida_ULA, 0);
      chk("rst2 sel", BR_Sel_E, 0);
      @(negedge clock);
      reset_n = 1;
      @(negedge clock);
      mem_rvalid = 1; mem_rdata = 16'hABCD;
      @(negedge clock);
      mem_rvalid = 0; mem_rdata = 16'hDEAD;
      chk("late rvalid md", saida_MD, 0);
      chk("late rvalid pulse", BR_Hab_Escrita, 0);
      repeat (3) @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
